// File: rtl/loopback_fifo.sv
// Show-ahead FIFO between the FX3 slave-FIFO read path and the loopback write-back stage.
// The head word is served from a registered read (plus write bypass), so dout depends only on registers.
module loopback_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int AFULL_LEVEL  = 1020,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                  clk_100,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   peak_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] head_q;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_next;
    logic [ADDR_WIDTH:0]   peak_next;
    logic                  push_ok;
    logic                  pop_ok;

    // Flush overrides both requests, so neither pointer nor memory moves that cycle.
    always_comb begin
        pop_ok      = pop & ~empty & ~flush;
        push_ok     = push & (~full | pop_ok) & ~flush;
        wr_ptr_next = wr_ptr + ADDR_WIDTH'(push_ok);
        rd_ptr_next = rd_ptr + ADDR_WIDTH'(pop_ok);
        count_next  = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
        if (flush) begin
            peak_next = '0;
        end else if (count_next > peak_count) begin
            peak_next = count_next;
        end else begin
            peak_next = peak_count;
        end
    end

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            peak_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            peak_count <= peak_next;
            if (flush) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (push & ~push_ok) overflow  <= 1'b1;
                if (pop & empty)     underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // The next head lives at rd_ptr_next; if that slot is being written this cycle, take din directly.
    always_ff @(posedge clk_100) begin
        if (push_ok && (wr_ptr == rd_ptr_next)) begin
            head_q <= din;
        end else begin
            head_q <= mem[rd_ptr_next];
        end
    end

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);
    assign dout         = empty ? '0 : head_q;

endmodule
